// File: rtl/uart_stream_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter between two
// 24-bit sample FIFOs. Each sample is sent as a 5-byte packet:
// HDR_BYTE, channel ID, data[23:16], data[15:8], data[7:0].
// Streaming is started/stopped by host command bytes.
//
// Ports:
//   CLK, reset            clock, synchronous active-high reset
//   cmd_valid, cmd_byte   host command strobe and byte
//   chN_empty, chN_data   FIFO status and q (valid 1 cycle after rdreq)
//   chN_rdreq             FIFO read request, 1-cycle pulse
//   tx_ready              UART TX idle
//   tx_start, tx_data     byte load strobe and byte (held until next strobe)
//   streaming             streaming enabled
//   busy                  packet in progress
//   last_ch               channel of the most recent grant
//   pkt_cnt               completed packets, wraps
module uart_stream_arbiter #(
  parameter logic [7:0] HDR_BYTE  = 8'hA5,
  parameter logic [7:0] CMD_START = 8'h19,
  parameter logic [7:0] CMD_STOP  = 8'h00,
  parameter logic [7:0] ID_CH0    = 8'h30,
  parameter logic [7:0] ID_CH1    = 8'h31
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_byte,
  input  logic        ch0_empty,
  input  logic [23:0] ch0_data,
  output logic        ch0_rdreq,
  input  logic        ch1_empty,
  input  logic [23:0] ch1_data,
  output logic        ch1_rdreq,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        streaming,
  output logic        busy,
  output logic        last_ch,
  output logic [15:0] pkt_cnt
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned SAMP_W = 24;
  localparam int unsigned CNT_W  = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(4);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_RD, S_LATCH, S_SEND, S_GUARD
  } state_t;

  state_t              state, state_d;
  logic [IDX_W-1:0]    idx, idx_d;
  logic [SAMP_W-1:0]   sample_reg, sample_d;
  logic                stop_pend, stop_pend_d;
  logic                streaming_d, last_ch_d, busy_d;
  logic                ch0_rdreq_d, ch1_rdreq_d, tx_start_d;
  logic [7:0]          tx_data_d, byte_sel;
  logic [CNT_W-1:0]    pkt_cnt_d;
  logic                cmd_start, cmd_stop, idle_like, pkt_done;
  logic                pref, pref_ok, other_ok;

  // State and output registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      sample_reg <= '0;
      stop_pend  <= 1'b0;
      streaming  <= 1'b0;
      last_ch    <= 1'b1;
      busy       <= 1'b0;
      ch0_rdreq  <= 1'b0;
      ch1_rdreq  <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      pkt_cnt    <= '0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      sample_reg <= sample_d;
      stop_pend  <= stop_pend_d;
      streaming  <= streaming_d;
      last_ch    <= last_ch_d;
      busy       <= busy_d;
      ch0_rdreq  <= ch0_rdreq_d;
      ch1_rdreq  <= ch1_rdreq_d;
      tx_start   <= tx_start_d;
      tx_data    <= tx_data_d;
      pkt_cnt    <= pkt_cnt_d;
    end
  end

  // Next-state, command decode and output logic
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    sample_d    = sample_reg;
    stop_pend_d = stop_pend;
    streaming_d = streaming;
    last_ch_d   = last_ch;
    pkt_cnt_d   = pkt_cnt;
    ch0_rdreq_d = 1'b0;
    ch1_rdreq_d = 1'b0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data;

    cmd_start = cmd_valid && (cmd_byte == CMD_START);
    cmd_stop  = cmd_valid && (cmd_byte == CMD_STOP);
    idle_like = (state == S_IDLE) || (state == S_ARB);
    pkt_done  = (state == S_GUARD) && (idx == LAST_IDX);

    // Round-robin: favour the channel that was not granted last
    pref     = ~last_ch;
    pref_ok  = pref ? ~ch1_empty : ~ch0_empty;
    other_ok = pref ? ~ch0_empty : ~ch1_empty;

    case (idx)
      IDX_W'(0): byte_sel = HDR_BYTE;
      IDX_W'(1): byte_sel = last_ch ? ID_CH1 : ID_CH0;
      IDX_W'(2): byte_sel = sample_reg[23:16];
      IDX_W'(3): byte_sel = sample_reg[15:8];
      default:   byte_sel = sample_reg[7:0];
    endcase

    case (state)
      S_IDLE: if (streaming) state_d = S_ARB;
      S_ARB: begin
        if (!streaming) begin
          state_d = S_IDLE;
        end else if (pref_ok || other_ok) begin
          last_ch_d   = pref_ok ? pref : ~pref;
          ch0_rdreq_d = ~last_ch_d;
          ch1_rdreq_d = last_ch_d;
          state_d     = S_RD;
        end
      end
      S_RD: state_d = S_LATCH;
      S_LATCH: begin
        sample_d = last_ch ? ch1_data : ch0_data;
        idx_d    = '0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          tx_start_d = 1'b1;
          tx_data_d  = byte_sel;
          state_d    = S_GUARD;
        end
      end
      S_GUARD: begin
        // TX core drops ready one cycle late; skip this cycle's tx_ready
        if (idx == LAST_IDX) begin
          pkt_cnt_d = pkt_cnt + CNT_W'(1);
          idx_d     = '0;
          state_d   = S_ARB;
        end else begin
          idx_d   = idx + IDX_W'(1);
          state_d = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Latest command wins; a pending stop takes effect only between packets
    if (cmd_start) begin
      stop_pend_d = 1'b0;
      streaming_d = 1'b1;
    end else begin
      if (cmd_stop) stop_pend_d = 1'b1;
      if ((stop_pend || cmd_stop) && (idle_like || pkt_done)) begin
        streaming_d = 1'b0;
        stop_pend_d = 1'b0;
      end
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_ARB);
  end

endmodule

// File: tb/tb_uart_stream_arbiter.sv
// Directed bench for uart_stream_arbiter: FIFO and TX models, byte/grant
// monitors, and immediate-assertion checks against hand-computed values.
module tb_uart_stream_arbiter;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_byte = 8'h00;
  logic        ch0_empty = 1'b1, ch1_empty = 1'b1;
  logic [23:0] ch0_data, ch1_data;
  logic        ch0_rdreq, ch1_rdreq;
  logic        tx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        streaming, busy, last_ch;
  logic [15:0] pkt_cnt;

  uart_stream_arbiter dut (
    .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .ch0_empty(ch0_empty), .ch0_data(ch0_data), .ch0_rdreq(ch0_rdreq),
    .ch1_empty(ch1_empty), .ch1_data(ch1_data), .ch1_rdreq(ch1_rdreq),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
    .streaming(streaming), .busy(busy), .last_ch(last_ch), .pkt_cnt(pkt_cnt)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [23:0] q0[$], q1[$];
  logic [23:0] q0_data = '0, q1_data = '0;
  logic [23:0] junk = '0;
  logic        scramble = 1'b0;
  logic        slow = 1'b0;
  logic        tx_en = 1'b1;
  int          hold = 0;
  int          rd_empty = 0;

  logic [7:0]  bytes_q[$];
  logic        grant_q[$];
  int          rd_cyc[$], tx_cyc[$];
  int          rd_bad = 0, tx_bad = 0;
  logic        rd_prev = 1'b0, tx_prev = 1'b0, ready_prev = 1'b1;

  assign ch0_data = scramble ? junk : q0_data;
  assign ch1_data = q1_data;
  assign tx_ready = tx_en && (hold == 0);

  always @(posedge CLK) cyc <= cyc + 1;

  // FIFO model: normal-mode q, one cycle read latency
  always @(posedge CLK) begin
    if (ch0_rdreq) begin
      if (q0.size() == 0) rd_empty <= rd_empty + 1;
      else q0_data <= q0.pop_front();
    end
    if (ch1_rdreq) begin
      if (q1.size() == 0) rd_empty <= rd_empty + 1;
      else q1_data <= q1.pop_front();
    end
    ch0_empty <= (q0.size() == 0);
    ch1_empty <= (q1.size() == 0);
  end

  // TX model: optionally drops ready for 10 cycles after each byte
  always @(posedge CLK) begin
    if (reset) hold <= 0;
    else if (slow && tx_start) hold <= 10;
    else if (hold != 0) hold <= hold - 1;
  end

  always @(negedge CLK) junk <= 24'($urandom);

  // Monitor: record bytes/grants and protocol violations
  always @(negedge CLK) begin
    if (!reset) begin
      if (ch0_rdreq) begin grant_q.push_back(1'b0); rd_cyc.push_back(cyc); end
      if (ch1_rdreq) begin grant_q.push_back(1'b1); rd_cyc.push_back(cyc); end
      if ((ch0_rdreq && ch1_rdreq) || ((ch0_rdreq || ch1_rdreq) && rd_prev))
        rd_bad <= rd_bad + 1;
      if (tx_start) begin
        bytes_q.push_back(tx_data);
        tx_cyc.push_back(cyc);
        if (!ready_prev || tx_prev) tx_bad <= tx_bad + 1;
      end
    end
    rd_prev    <= ch0_rdreq | ch1_rdreq;
    tx_prev    <= tx_start;
    ready_prev <= tx_ready;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_byte  = b;
    tick();
    cmd_valid = 1'b0;
    cmd_byte  = 8'h00;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (bytes_q.size() < n && k < budget) begin tick(); k++; end
    chk("byte_count_wait", 32'(bytes_q.size()), 32'(n));
  endtask

  task automatic chk_pkt(input string tag, input int base, input logic [7:0] id,
                         input logic [23:0] d);
    logic [7:0] exp[5];
    exp[0] = 8'hA5; exp[1] = id; exp[2] = d[23:16]; exp[3] = d[15:8]; exp[4] = d[7:0];
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s_byte%0d", tag, i),
          (base + i < bytes_q.size()) ? 32'(bytes_q[base + i]) : 32'hDEAD,
          32'(exp[i]));
  endtask

  task automatic clear_mon();
    bytes_q.delete(); grant_q.delete(); rd_cyc.delete(); tx_cyc.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdreq0"}, 32'(ch0_rdreq), 0);
    chk({tag, "_rdreq1"}, 32'(ch1_rdreq), 0);
    chk({tag, "_tx_start"}, 32'(tx_start), 0);
    chk({tag, "_tx_data"}, 32'(tx_data), 0);
    chk({tag, "_streaming"}, 32'(streaming), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_last_ch"}, 32'(last_ch), 1);
    chk({tag, "_pkt_cnt"}, 32'(pkt_cnt), 0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk_reset_outs("rst");
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_no_grant", 32'(grant_q.size()), 0);

    // 1: single ch0 sample
    q0.push_back(24'h123456);
    repeat (2) tick();
    send_cmd(8'h19);
    wait_bytes(5, 100);
    chk_pkt("t1", 0, 8'h30, 24'h123456);
    chk("t1_grants", 32'(grant_q.size()), 1);
    chk("t1_grant_ch", 32'(grant_q.size() > 0 ? grant_q[0] : 1'bx), 0);
    chk("t1_latency", 32'(tx_cyc[0] - rd_cyc[0]), 3);
    chk("t1_spacing", 32'(tx_cyc[1] - tx_cyc[0]), 2);
    repeat (3) tick();
    chk("t1_pkt_cnt", 32'(pkt_cnt), 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_streaming", 32'(streaming), 1);

    // 2: both FIFOs with 3 words, round-robin from reset
    reset = 1'b1; tick(); reset = 1'b0;
    clear_mon();
    for (int i = 1; i <= 3; i++) begin
      q0.push_back(24'h100000 + 24'(i));
      q1.push_back(24'h200000 + 24'(i));
    end
    repeat (2) tick();
    send_cmd(8'h19);
    wait_bytes(30, 400);
    for (int p = 0; p < 6; p++) begin
      chk($sformatf("t2_grant%0d", p), 32'(p < grant_q.size() ? grant_q[p] : 1'bx), 32'(p % 2));
      chk_pkt($sformatf("t2_p%0d", p), 5 * p, (p % 2 == 0) ? 8'h30 : 8'h31,
              ((p % 2 == 0) ? 24'h100000 : 24'h200000) + 24'(p / 2 + 1));
    end
    repeat (20) tick();
    chk("t2_pkt_cnt", 32'(pkt_cnt), 6);
    chk("t2_no_extra_grant", 32'(grant_q.size()), 6);

    // 3: STOP after 2nd byte completes the packet, then no more reads
    clear_mon();
    q0.push_back(24'hABCDEF); q0.push_back(24'h111111); q1.push_back(24'h222222);
    wait_bytes(2, 100);
    send_cmd(8'h00);
    wait_bytes(4, 100);
    for (int k = 0; k < 20 && tx_start !== 1'b1; k++) tick();
    chk("t3_stream_in_last_guard", 32'(streaming), 1);
    tick();
    chk("t3_stream_dropped", 32'(streaming), 0);
    chk_pkt("t3", 0, 8'h30, 24'hABCDEF);
    repeat (30) tick();
    chk("t3_grants", 32'(grant_q.size()), 1);
    chk("t3_pkt_cnt", 32'(pkt_cnt), 7);

    // 4: slow TX, ch0_data scrambled while packet is in flight
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    q0.delete(); q1.delete(); clear_mon();
    q0.push_back(24'h5A6B7C);
    slow = 1'b1;
    repeat (2) tick();
    send_cmd(8'h19);
    wait_bytes(1, 100);
    scramble = 1'b1;
    wait_bytes(5, 300);
    chk_pkt("t4", 0, 8'h30, 24'h5A6B7C);
    chk("t4_gap", 32'(tx_cyc[2] - tx_cyc[1]), 12);
    scramble = 1'b0;
    slow = 1'b0;
    repeat (15) tick();

    // 5: reset while byte index 3 is pending
    clear_mon();
    q0.push_back(24'h0A0B0C); q0.push_back(24'h0D0E0F);
    repeat (2) tick();
    wait_bytes(3, 100);
    reset = 1'b1;
    tick();
    chk_reset_outs("t5");
    reset = 1'b0;
    repeat (3) tick();
    chk("t5_no_resume", 32'(bytes_q.size()), 3);
    clear_mon();
    send_cmd(8'h19);
    wait_bytes(5, 100);
    chk_pkt("t5", 0, 8'h30, 24'h0D0E0F);
    repeat (3) tick();

    // 6: pkt_cnt wrap; also ignored byte and STOP-then-START in one packet
    force dut.pkt_cnt = 16'hFFFF;
    tick();
    release dut.pkt_cnt;
    tick();
    chk("t6_preload", 32'(pkt_cnt), 32'hFFFF);
    clear_mon();
    q0.push_back(24'h777777);
    send_cmd(8'h55);
    wait_bytes(2, 100);
    send_cmd(8'h00);
    send_cmd(8'h19);
    wait_bytes(5, 100);
    repeat (3) tick();
    chk("t6_wrap", 32'(pkt_cnt), 0);
    chk("t6_start_wins", 32'(streaming), 1);
    chk_pkt("t6", 0, 8'h30, 24'h777777);

    // Protocol monitors
    chk("rdreq_on_empty", 32'(rd_empty), 0);
    chk("rdreq_shape", 32'(rd_bad), 0);
    chk("tx_start_shape", 32'(tx_bad), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_stream_arbiter.md
Name: uart_stream_arbiter

Overview:
Shares the single byte-wide UART transmitter between two 24-bit sample FIFOs (sensor channel 0 and channel 1). Streaming is started and stopped by host command bytes. Arbitration between the channels is round-robin. Each sample goes out as a 5-byte packet: header, channel ID, then data bits [23:16], [15:8], [7:0]. The block sits between the SPI-side sample FIFOs and the UART TX core, and replaces per-channel ad-hoc sequencing.

Parameters:
HDR_BYTE, 8'hA5, first byte of every packet.
CMD_START, 8'h19, host command that enables streaming.
CMD_STOP, 8'h00, host command that disables streaming after the current packet.
ID_CH0, 8'h30, channel-ID byte sent for channel 0.
ID_CH1, 8'h31, channel-ID byte sent for channel 1.

Ports:
CLK  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  one-cycle strobe; cmd_byte valid
cmd_byte  in  8  host command byte from UART RX
ch0_empty  in  1  channel 0 FIFO empty
ch0_data  in  24  channel 0 FIFO q; normal mode, valid 1 cycle after rdreq
ch0_rdreq  out  1  channel 0 FIFO read request (1-cycle pulse)
ch1_empty  in  1  channel 1 FIFO empty
ch1_data  in  24  channel 1 FIFO q; same timing as ch0_data
ch1_rdreq  out  1  channel 1 FIFO read request (1-cycle pulse)
tx_ready  in  1  UART TX idle, can accept a byte
tx_start  out  1  one-cycle strobe; load tx_data
tx_data  out  8  byte to transmit; held until the next tx_start
streaming  out  1  streaming enabled
busy  out  1  packet in progress (state != IDLE/ARB)
last_ch  out  1  channel of the most recent grant
pkt_cnt  out  16  completed packets; wraps FFFF->0000

Behaviour:
- Reset values: all outputs 0, state IDLE, streaming 0, last_ch 1 (so channel 0 wins the first arbitration), internal byte index 0.
- Command decode runs every cycle, independent of state:
  - cmd_valid && cmd_byte==CMD_START sets stop_pend=0 and streaming=1.
  - cmd_valid && cmd_byte==CMD_STOP sets stop_pend=1.
  - All other bytes are ignored.
  - stop_pend clears streaming when the FSM is in IDLE or ARB (immediately if already idle), or on completion of the current packet's last byte.
- States:
  - IDLE: go to ARB when streaming=1.
  - ARB:
    - If streaming=0, go to IDLE.
    - Round-robin: prefer the channel != last_ch when it is non-empty; otherwise take the other channel if it is non-empty; if both are empty, stay in ARB.
    - On grant: pulse the chosen chX_rdreq for exactly 1 cycle, update last_ch, go to RD.
  - RD: wait 1 cycle for FIFO latency, go to LATCH.
  - LATCH: capture chX_data[23:0] into sample_reg, set byte index to 0, go to SEND.
  - SEND: when tx_ready=1, drive tx_data with the selected byte, pulse tx_start for 1 cycle, go to GUARD.
    - Index 0 = HDR_BYTE; 1 = channel ID; 2 = sample[23:16]; 3 = sample[15:8]; 4 = sample[7:0].
  - GUARD: ignore tx_ready for exactly 1 cycle, because the TX core drops ready one cycle late. Then:
    - If index==4: pkt_cnt+1, index 0, go to ARB.
    - Otherwise: index+1, go to SEND.
- Latency:
  - Grant (rdreq) to first tx_start is 3 cycles when tx_ready is already high.
  - Minimum spacing between consecutive tx_start pulses is 2 cycles.
- The FIFO is never read unless its empty=0 in the grant cycle. At most one rdreq is outstanding. Never more than one rdreq per packet.
- Changes to empty or data during SEND/GUARD do not affect the packet in flight; sample_reg is stable.
- A START command while streaming is a no-op, except that it cancels a pending STOP.
- STOP and START arriving in the same packet: the last command received wins.
- Reset asserted mid-packet: abort immediately, apply reset values; a partially sent packet is not resumed. A FIFO word already popped is lost; this is accepted.
- tx_ready held low indefinitely: the FSM waits in SEND; no timeout.

Test Plan:
1. Reset, START, ch0 holds 24'h123456, ch1 empty, tx_ready=1 -> ch0_rdreq one pulse; tx_data sequence A5,30,12,34,56; pkt_cnt=1; back in ARB.
2. Both FIFOs hold 3 words each, streaming on -> grant order ch0,ch1,ch0,ch1,ch0,ch1; ID bytes alternate 30/31; pkt_cnt=6; no rdreq while empty=1.
3. STOP issued after the 2nd byte of a packet -> packet completes all 5 bytes, streaming drops the cycle after the 5th GUARD, no further rdreq although FIFOs are non-empty.
4. tx_ready toggled low for 10 cycles after each tx_start -> each byte waits, no tx_start while tx_ready=0, byte order unchanged, sample_reg stable while ch0_data changes.
5. Reset pulsed during byte index 3 -> next cycle: all outputs 0, last_ch=1, FSM IDLE; after START, the next packet starts with A5.
6. pkt_cnt preloaded via 65535 packets (or forced) -> next packet wraps pkt_cnt to 0.
